ram_bist_ctrl: RTL and testbench
================================

// Module: ram_bist_ctrl
// PURPOSE
//  Built-in self-test sequencer for the 64x8 simple dual-port RAM demo block, sharing one clock.
//  Sequences a full write pass, then a full read pass, and compares the read data against the
//  expected pattern. Reports busy/done/pass and a saturating error count to the demo top.
// PARAMETERS
//  ADDR_W     6   RAM address width; DEPTH = 2**ADDR_W
//  DATA_W     8   RAM data width
//  RD_LAT     2   cycles from ram_rd_addr to valid ram_rd_data (2 = output register on); legal 1..4
//  ERR_CNT_W  4   error counter width; saturates at 2**ERR_CNT_W-1
// PORTS
//  sys_clk      in   1          single clock for controller and both RAM ports
//  rst_n        in   1          asynchronous, active-low reset
//  start        in   1          1-cycle request; sampled only in IDLE
//  abort        in   1          synchronous abort; any state -> IDLE
//  seed         in   DATA_W     pattern seed, captured on accepted start
//  busy         out  1          high in WRITE/READ/DRAIN
//  done         out  1          1-cycle pulse in DONE
//  pass         out  1          result; valid from done until the next accepted start
//  err_cnt      out  ERR_CNT_W  mismatch count, saturating
//  ram_wr_en    out  1          RAM write enable
//  ram_wr_addr  out  ADDR_W     RAM write address
//  ram_wr_data  out  DATA_W     RAM write data
//  ram_rd_addr  out  ADDR_W     RAM read address
//  ram_rd_data  in   DATA_W     RAM read data, RD_LAT after ram_rd_addr
// BEHAVIOUR
//  - Reset: state=IDLE; all outputs 0; seed register and compare pipeline cleared.
//  - FSM: IDLE -start-> WRITE -last addr-> READ -last addr-> DRAIN -RD_LAT cycles-> DONE -> IDLE.
//  - Pattern: exp(a) = ~a (zero-extended to DATA_W) ^ seed_q. With seed 0 this is a down-count from 0xFF.
//  - WRITE: one address per cycle, a = 0..DEPTH-1, with ram_wr_en=1 and ram_wr_data=exp(a).
//  - READ: one address per cycle, a = 0..DEPTH-1. A valid/expected shift pipe of depth RD_LAT
//    aligns exp(a) with ram_rd_data. Each valid mismatch increments err_cnt; err_cnt holds at all-ones.
//  - DRAIN: RD_LAT cycles with no new reads, so the final compares retire.
//  - DONE: done=1 for one cycle; pass=(err_cnt==0) registered at the same edge.
//  - Timing with defaults: start accepted at edge 0 -> writes in cycles 1..64, reads in 65..128,
//    drain in 129..130, done in cycle 131.
//  - Address counter is ADDR_W+1 bits wide, so the last-address test needs no wrap-around.
//  - Outside its own state, each RAM output is driven to 0.
//  - start while not IDLE: ignored, no queuing.
//  - An accepted start clears err_cnt and pass.
//  - start in the DONE cycle: ignored.
//  - abort: next state IDLE, busy=0, no done pulse, err_cnt and pass cleared. The compare pipe
//    is flushed. abort has priority over start when both are asserted in the same cycle.
//  - rst_n low mid-operation: immediate return to the reset values; no done.
// CONFIGURATION
//  Macro RAM_BIST_ERR_LOG_EN.
//  - Defined: adds output ports first_err_vld(1), first_err_addr(ADDR_W) and first_err_data(DATA_W).
//    These capture the address and the read data of the first mismatch after start.
//    They are cleared on reset, start and abort, and held until the next start.
//  - Not defined: these ports and registers do not exist; all other behaviour is identical.
// STRUCTURE
//  - Package ram_bist_pkg: state enum (IDLE, WRITE, READ, DRAIN, DONE) and function
//    bist_pattern(addr, seed).
//  - Sub-module ram_bist_cmp: RD_LAT-deep valid/expected pipe, comparator, saturating err_cnt
//    and the optional first-error log.
//  - The top holds the FSM and the address counter.
// TESTING
//  1 Bench RAM model with 2-cycle read; seed=0x00; pulse start -> done at cycle 131, pass=1,
//    err_cnt=0, wr_data@addr0=0xFF, wr_data@addr63=0xC0.
//  2 seed=0xA5 -> wr_data@addr0=0x5A; run passes; pass=1.
//  3 Model flips bit0 on read of addr 0x05 -> err_cnt=1, pass=0;
//    with RAM_BIST_ERR_LOG_EN: first_err_addr=0x05, first_err_data=0xFB.
//  4 Model returns 0x00 on all reads (seed 0) -> err_cnt saturates at 15, pass=0.
//  5 Re-pulse start in cycle 40 -> ignored, done still at cycle 131.
//    abort in cycle 30 of a new run -> busy=0 next cycle, no done, err_cnt=0.
//  6 Drop rst_n in cycle 90 (READ) -> all outputs 0 immediately.
//    After release, a new start completes with pass=1.

Source files
------------

// File: rtl/ram_bist_pkg.sv
// Shared types and the test pattern for the RAM BIST controller.
// Used by ram_bist_ctrl and ram_bist_cmp; error logging is enabled with RAM_BIST_ERR_LOG_EN.
package ram_bist_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WRITE = 3'd1,
    READ  = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } bist_state_t;

  // Callers truncate the result to DATA_W, so inverting the zero-extended address is implicit.
  function automatic logic [31:0] bist_pattern(input logic [31:0] addr, input logic [31:0] seed);
    return (~addr) ^ seed;
  endfunction

endpackage

// File: rtl/ram_bist_if.sv
// RAM port bundle between the BIST controller (master) and the dual-port RAM (slave).
// Both RAM ports share the controller clock, so no clock travels in the interface.
interface ram_bist_if #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 8
);

  logic              ram_wr_en;
  logic [ADDR_W-1:0] ram_wr_addr;
  logic [DATA_W-1:0] ram_wr_data;
  logic [ADDR_W-1:0] ram_rd_addr;
  logic [DATA_W-1:0] ram_rd_data;

  modport master (
    output ram_wr_en,
    output ram_wr_addr,
    output ram_wr_data,
    output ram_rd_addr,
    input  ram_rd_data
  );

  modport slave (
    input  ram_wr_en,
    input  ram_wr_addr,
    input  ram_wr_data,
    input  ram_rd_addr,
    output ram_rd_data
  );

endinterface

// File: rtl/ram_bist_cmp.sv
// Read-data checker: RD_LAT-deep valid/expected pipe, comparator and saturating error count.
// With RAM_BIST_ERR_LOG_EN defined it also logs the address and data of the first mismatch.
module ram_bist_cmp
  import ram_bist_pkg::*;
#(
  parameter int ADDR_W    = 6,
  parameter int DATA_W    = 8,
  parameter int RD_LAT    = 2,
  parameter int ERR_CNT_W = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic                 push_vld,
  input  logic [DATA_W-1:0]    push_exp,
`ifdef RAM_BIST_ERR_LOG_EN
  input  logic [ADDR_W-1:0]    push_addr,
  output logic                 first_err_vld,
  output logic [ADDR_W-1:0]    first_err_addr,
  output logic [DATA_W-1:0]    first_err_data,
`endif
  input  logic [DATA_W-1:0]    rd_data,
  output logic [ERR_CNT_W-1:0] err_cnt,
  output logic                 clean
);

  logic [RD_LAT-1:0] vld_pipe;
  logic [DATA_W-1:0] exp_pipe [RD_LAT];
  logic              mismatch;
  logic              err_full;

  always_comb begin
    mismatch = vld_pipe[RD_LAT-1] && (rd_data != exp_pipe[RD_LAT-1]);
    err_full = &err_cnt;
    // Includes the compare retiring this cycle, so the result can be latched on the last drain edge.
    clean    = (err_cnt == '0) && !mismatch;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      for (int i = 0; i < RD_LAT; i++) exp_pipe[i] <= '0;
    end else if (clear) begin
      vld_pipe <= '0;
      for (int i = 0; i < RD_LAT; i++) exp_pipe[i] <= '0;
    end else begin
      vld_pipe[0] <= push_vld;
      exp_pipe[0] <= push_exp;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        exp_pipe[i] <= exp_pipe[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= '0;
    end else if (clear) begin
      err_cnt <= '0;
    end else if (mismatch && !err_full) begin
      err_cnt <= err_cnt + 1'b1;
    end
  end

`ifdef RAM_BIST_ERR_LOG_EN
  logic [ADDR_W-1:0] addr_pipe [RD_LAT];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RD_LAT; i++) addr_pipe[i] <= '0;
    end else if (clear) begin
      for (int i = 0; i < RD_LAT; i++) addr_pipe[i] <= '0;
    end else begin
      addr_pipe[0] <= push_addr;
      for (int i = 1; i < RD_LAT; i++) addr_pipe[i] <= addr_pipe[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      first_err_vld  <= 1'b0;
      first_err_addr <= '0;
      first_err_data <= '0;
    end else if (clear) begin
      first_err_vld  <= 1'b0;
      first_err_addr <= '0;
      first_err_data <= '0;
    end else if (mismatch && !first_err_vld) begin
      first_err_vld  <= 1'b1;
      first_err_addr <= addr_pipe[RD_LAT-1];
      first_err_data <= rd_data;
    end
  end
`endif

endmodule

// File: rtl/ram_bist_ctrl.sv
// RAM BIST sequencer: write pass, read pass, drain, then a done pulse with pass/err_cnt.
// Define RAM_BIST_ERR_LOG_EN to add the first_err_* logging ports.
module ram_bist_ctrl
  import ram_bist_pkg::*;
#(
  parameter int ADDR_W    = 6,
  parameter int DATA_W    = 8,
  parameter int RD_LAT    = 2,
  parameter int ERR_CNT_W = 4
) (
  input  logic                 sys_clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic [DATA_W-1:0]    seed,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [ERR_CNT_W-1:0] err_cnt,
`ifdef RAM_BIST_ERR_LOG_EN
  output logic                 first_err_vld,
  output logic [ADDR_W-1:0]    first_err_addr,
  output logic [DATA_W-1:0]    first_err_data,
`endif
  ram_bist_if.master           ram
);

  localparam int              DEPTH      = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] LAST_ADDR  = (ADDR_W + 1)'(DEPTH - 1);
  localparam logic [ADDR_W:0] LAST_DRAIN = (ADDR_W + 1)'(RD_LAT - 1);

  bist_state_t       state, state_next;
  logic [ADDR_W:0]   cnt, cnt_next;
  logic [DATA_W-1:0] seed_q;
  logic [DATA_W-1:0] exp_data;
  logic              start_ok;
  logic              cmp_clear;
  logic              cmp_clean;

  always_comb begin
    start_ok  = (state == IDLE) && start && !abort;
    cmp_clear = start_ok || abort;
    exp_data  = DATA_W'(bist_pattern(32'(cnt[ADDR_W-1:0]), 32'(seed_q)));
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // One counter serves as write address, read address and drain timer; it restarts at each phase.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      IDLE: begin
        if (start_ok) begin
          state_next = WRITE;
          cnt_next   = '0;
        end
      end
      WRITE: begin
        if (cnt == LAST_ADDR) begin
          state_next = READ;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      READ: begin
        if (cnt == LAST_ADDR) begin
          state_next = DRAIN;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      DRAIN: begin
        if (cnt == LAST_DRAIN) begin
          state_next = DONE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      DONE: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
    if (abort) begin
      state_next = IDLE;
      cnt_next   = '0;
    end
  end

  always_comb begin
    busy            = (state == WRITE) || (state == READ) || (state == DRAIN);
    done            = (state == DONE);
    ram.ram_wr_en   = (state == WRITE);
    ram.ram_wr_addr = (state == WRITE) ? cnt[ADDR_W-1:0] : '0;
    ram.ram_wr_data = (state == WRITE) ? exp_data : '0;
    ram.ram_rd_addr = (state == READ)  ? cnt[ADDR_W-1:0] : '0;
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      seed_q <= '0;
    end else if (start_ok) begin
      seed_q <= seed;
    end
  end

  // The verdict is latched on the edge entering DONE, so it is already valid while done is high.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      pass <= 1'b0;
    end else if (cmp_clear) begin
      pass <= 1'b0;
    end else if ((state == DRAIN) && (cnt == LAST_DRAIN)) begin
      pass <= cmp_clean;
    end
  end

  ram_bist_cmp #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .RD_LAT   (RD_LAT),
    .ERR_CNT_W(ERR_CNT_W)
  ) u_cmp (
    .clk           (sys_clk),
    .rst_n         (rst_n),
    .clear         (cmp_clear),
    .push_vld      (state == READ),
    .push_exp      (exp_data),
`ifdef RAM_BIST_ERR_LOG_EN
    .push_addr     (cnt[ADDR_W-1:0]),
    .first_err_vld (first_err_vld),
    .first_err_addr(first_err_addr),
    .first_err_data(first_err_data),
`endif
    .rd_data       (ram.ram_rd_data),
    .err_cnt       (err_cnt),
    .clean         (cmp_clean)
  );

endmodule

// File: tb/tb_ram_bist_ctrl.sv
// Self-checking bench for ram_bist_ctrl with a 2-cycle-read RAM model and fault injection.
// Honours RAM_BIST_ERR_LOG_EN for the first-error log ports.
`timescale 1ns/1ps
module tb_ram_bist_ctrl;

  localparam int ADDR_W = 6;
  localparam int DATA_W = 8;
  localparam int RD_LAT = 2;
  localparam int ERR_W  = 4;
  localparam int DEPTH  = 64;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic [7:0]       seed = 8'h00;
  logic             busy, done, pass;
  logic [ERR_W-1:0] err_cnt;
`ifdef RAM_BIST_ERR_LOG_EN
  logic             first_err_vld;
  logic [5:0]       first_err_addr;
  logic [7:0]       first_err_data;
`endif

  int checks = 0;
  int failures = 0;

  ram_bist_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) ram_if ();

  ram_bist_ctrl #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT), .ERR_CNT_W(ERR_W)
  ) dut (
    .sys_clk       (clk),
    .rst_n         (rst_n),
    .start         (start),
    .abort         (abort),
    .seed          (seed),
    .busy          (busy),
    .done          (done),
    .pass          (pass),
    .err_cnt       (err_cnt),
`ifdef RAM_BIST_ERR_LOG_EN
    .first_err_vld (first_err_vld),
    .first_err_addr(first_err_addr),
    .first_err_data(first_err_data),
`endif
    .ram           (ram_if)
  );

  always #5 clk = ~clk;

  // RAM model: stores writes, returns stored data XOR an injected corruption mask two cycles later.
  logic [7:0] mem     [DEPTH];
  logic [7:0] corrupt [DEPTH];
  bit         zero_mode = 1'b0;
  logic [7:0] cur_seed = 8'h00;
  logic [7:0] rd_p1 = 8'h00;
  logic [7:0] rd_p2 = 8'h00;
  int         wr_count = 0;
  int         wr_bad = 0;
  logic [7:0] wr_first = 8'h00;
  logic [7:0] wr_last = 8'h00;

  assign ram_if.ram_rd_data = rd_p2;

  function automatic logic [7:0] expPattern(input int a, input logic [7:0] s);
    return 8'(255 - a) ^ s;
  endfunction

  always @(posedge clk) begin
    if (ram_if.ram_wr_en) begin
      mem[ram_if.ram_wr_addr] <= ram_if.ram_wr_data;
      wr_count = wr_count + 1;
      if (ram_if.ram_wr_data !== expPattern(int'(ram_if.ram_wr_addr), cur_seed)) wr_bad = wr_bad + 1;
      if (ram_if.ram_wr_addr == 6'd0)  wr_first = ram_if.ram_wr_data;
      if (ram_if.ram_wr_addr == 6'd63) wr_last  = ram_if.ram_wr_data;
    end
    rd_p1 <= zero_mode ? 8'h00 : (mem[ram_if.ram_rd_addr] ^ corrupt[ram_if.ram_rd_addr]);
    rd_p2 <= rd_p1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", tag, act, exp);
    end
  endtask

  task automatic clearCorrupt();
    for (int a = 0; a < DEPTH; a++) corrupt[a] = 8'h00;
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic applyStimulus(input logic [7:0] s);
    @(negedge clk);
    cur_seed = s;
    seed     = s;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    seed  = 8'($urandom);
  endtask

  // Full run; the reference counts mismatches from what an ideal RAM plus the fault model returns.
  task automatic runTest(input string name, input logic [7:0] s, input bit zmode, input int restart_at);
    int         exp_err;
    int         first_a;
    logic [7:0] first_d;
    logic [7:0] ret;
    int         done_cyc;
    int         wc0;
    int         wb0;
    exp_err = 0;
    first_a = -1;
    first_d = 8'h00;
    for (int a = 0; a < DEPTH; a++) begin
      ret = zmode ? 8'h00 : (expPattern(a, s) ^ corrupt[a]);
      if (ret != expPattern(a, s)) begin
        exp_err++;
        if (first_a < 0) begin
          first_a = a;
          first_d = ret;
        end
      end
    end
    if (exp_err > 15) exp_err = 15;
    zero_mode = zmode;
    wc0 = wr_count;
    wb0 = wr_bad;
    done_cyc = 0;
    applyStimulus(s);
    for (int n = 1; n <= 400; n++) begin
      if (done) begin
        done_cyc = n;
        break;
      end
      if (n == 1) begin
        checkOutput({name, "_c1_wr"}, {busy, ram_if.ram_wr_en, 2'b00, ram_if.ram_wr_addr}, {1'b1, 1'b1, 2'b00, 6'd0});
        checkOutput({name, "_c1_clr"}, {pass, err_cnt}, 5'd0);
      end
      if (n == 66) checkOutput({name, "_c66_rd"}, {ram_if.ram_wr_en, ram_if.ram_rd_addr}, {1'b0, 6'd1});
      if (n == restart_at) begin
        start = 1'b1;
        seed  = ~s;
      end
      @(posedge clk);
      #1;
      start = 1'b0;
    end
    checkOutput({name, "_done_cyc"}, done_cyc, 131);
    checkOutput({name, "_busy_done"}, busy, 1'b0);
    checkOutput({name, "_err"}, err_cnt, exp_err);
    checkOutput({name, "_pass"}, pass, exp_err == 0);
    checkOutput({name, "_wr_cnt"}, wr_count - wc0, 64);
    checkOutput({name, "_wr_bad"}, wr_bad - wb0, 0);
    checkOutput({name, "_wr0"}, wr_first, expPattern(0, s));
    checkOutput({name, "_wr63"}, wr_last, expPattern(63, s));
`ifdef RAM_BIST_ERR_LOG_EN
    checkOutput({name, "_ferr_vld"}, first_err_vld, first_a >= 0);
    if (first_a >= 0) begin
      checkOutput({name, "_ferr_addr"}, first_err_addr, first_a);
      checkOutput({name, "_ferr_data"}, first_err_data, first_d);
    end
`endif
    // A start during DONE must be dropped and the result held.
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    checkOutput({name, "_after_done"}, {busy, done, pass, err_cnt}, {2'b00, exp_err == 0, 4'(exp_err)});
    zero_mode = 1'b0;
  endtask

  task automatic abortTest(input string name, input logic [7:0] s, input int abort_at, input int pre_err);
    int done_seen;
    cur_seed = s;
    applyStimulus(s);
    for (int n = 1; n < abort_at; n++) begin
      @(posedge clk);
      #1;
    end
    checkOutput({name, "_pre_err"}, err_cnt, pre_err);
    abort = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    start = 1'b0;
    checkOutput({name, "_post"}, {busy, done, pass, err_cnt}, 7'd0);
`ifdef RAM_BIST_ERR_LOG_EN
    checkOutput({name, "_ferr_clr"}, first_err_vld, 1'b0);
`endif
    done_seen = 0;
    for (int n = 0; n < 150; n++) begin
      @(posedge clk);
      #1;
      if (done || busy) done_seen++;
    end
    checkOutput({name, "_no_done"}, done_seen, 0);
  endtask

  task automatic resetTest(input string name, input logic [7:0] s, input int reset_at);
    cur_seed = s;
    applyStimulus(s);
    for (int n = 1; n < reset_at; n++) begin
      @(posedge clk);
      #1;
    end
    checkOutput({name, "_busy_pre"}, busy, 1'b1);
    rst_n = 1'b0;
    #1;
    checkOutput({name, "_outs"},
                {busy, done, pass, err_cnt, ram_if.ram_wr_en, ram_if.ram_wr_addr, ram_if.ram_wr_data, ram_if.ram_rd_addr},
                28'd0);
    idleCycles(3);
    rst_n = 1'b1;
    idleCycles(2);
    checkOutput({name, "_idle"}, {busy, done}, 2'b00);
  endtask

  initial begin
    clearCorrupt();
    rst_n = 1'b0;
    idleCycles(3);
    checkOutput("rst_status", {busy, done, pass, err_cnt}, 7'd0);
    checkOutput("rst_ram", {ram_if.ram_wr_en, ram_if.ram_wr_addr, ram_if.ram_wr_data, ram_if.ram_rd_addr}, 21'd0);
`ifdef RAM_BIST_ERR_LOG_EN
    checkOutput("rst_ferr", {first_err_vld, first_err_addr, first_err_data}, 15'd0);
`endif
    rst_n = 1'b1;
    idleCycles(2);

    runTest("seed00", 8'h00, 1'b0, 0);
    idleCycles(2);
    runTest("seedA5", 8'hA5, 1'b0, 0);
    idleCycles(2);
    corrupt[5] = 8'h01;
    runTest("flip5", 8'h00, 1'b0, 0);
    clearCorrupt();
    idleCycles(2);
    runTest("zeros", 8'h00, 1'b1, 0);
    idleCycles(2);
    runTest("restart40", 8'($urandom), 1'b0, 40);
    idleCycles(2);
    abortTest("abort30", 8'($urandom), 30, 0);
    corrupt[5] = 8'h01;
    abortTest("abort100", 8'h00, 100, 1);
    clearCorrupt();
    resetTest("reset90", 8'($urandom), 90);
    runTest("post_reset", 8'($urandom), 1'b0, 0);

    for (int r = 0; r < 6; r++) begin
      clearCorrupt();
      for (int k = 0; k < int'($urandom_range(0, 3)); k++) begin
        corrupt[$urandom_range(0, DEPTH - 1)] = 8'($urandom_range(1, 255));
      end
      idleCycles(1 + int'($urandom_range(0, 3)));
      runTest($sformatf("rand%0d", r), 8'($urandom), 1'b0, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
